// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multi-cycle RV32I control FSM.
//
// Contents:
//   state_t        control FSM states
//   OP_*           supported opcodes
//   ALUOP_*, SRCA_*, SRCB_*, RES_*, IMM_*  datapath select encodings
//   is_mem_state   states that drive the unified memory port
//   imm_src_for    immediate format for an opcode
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // States that hold a request on the memory port and therefore run the wait timer.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

    function automatic logic [1:0] imm_src_for(input logic [6:0] opcode);
        logic [1:0] imm;
        case (opcode)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: memory wait counter for the multi-cycle control FSM.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         force the count to zero (takes priority over en)
//   en          count one more wait cycle
//   expired     count has reached TIMEOUT_CYCLES (never set when TIMEOUT_CYCLES is 0)
//
// The count saturates at all-ones so a disabled timeout can never wrap back
// into a false expiry.
module mc_wait_timer
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle RV32I core.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   op                   opcode from the instruction register
//   Zero                 ALU zero flag (BEQ decision)
//   mem_ready            memory completes the current request this cycle
//   mem_req, MemWrite    memory request and write qualifier
//   AdrSrc               memory address: 0 = PC, 1 = ALU result register
//   IRWrite, PCWrite     instruction register / PC load strobes
//   RegWrite             register file write strobe
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc   datapath selects
//   illegal, bus_err     sticky trap flags (unsupported opcode, memory timeout)
//   instret              retired-instruction count
//
// Build option: define MC_PERF_CNT_EN to build the instret counter;
// otherwise instret is tied to zero.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ImmSrc,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instret
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   bus_err_q, bus_err_d;
    logic   wait_clr, wait_en, wait_expired;

    // The timer restarts whenever we are outside a memory state or about to
    // change state, so each memory state is entered with a zero count.
    assign wait_clr = !is_mem_state(state_q) || (state_d != state_q);
    assign wait_en  = is_mem_state(state_q) && !mem_ready;

    mc_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wait_clr),
        .en      (wait_en),
        .expired (wait_expired)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_ADD;

        case (state_q)
            S_START: state_d = S_FETCH;

            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                // A ready on the expiry cycle still completes normally.
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end

            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_IALU:      state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end

            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_expired) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end

            S_MEMWB: begin
                ResultSrc = RES_RDATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end

            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (wait_expired) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end

            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end

            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end

            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end

            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_SUB;
                PCWrite = Zero;
                state_d = S_FETCH;
            end

            // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end

            S_TRAP: state_d = S_TRAP;

            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_START;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign ImmSrc  = imm_src_for(op);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

`ifdef MC_PERF_CNT_EN
    logic        retire;
    logic [31:0] instret_q, instret_d;

    // JAL is counted once, when it leaves through ALUWB.
    assign retire = (state_q == S_MEMWB) ||
                    ((state_q == S_MEMWRITE) && mem_ready) ||
                    (state_q == S_ALUWB) ||
                    (state_q == S_BEQ);

    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
// The DUT is built with TIMEOUT_CYCLES = 4 so the memory timeout is reachable
// in a few cycles. Inputs change on the falling edge; outputs are sampled 1ns
// later, well away from the rising edge that advances the FSM.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BAD  = 7'b0000000;

    // Expected control word per state:
    // {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
    localparam logic [13:0] CTL_IDLE      = 14'b0_0_0_0_0_0_00_00_00_00;
    localparam logic [13:0] CTL_FETCH_RDY = 14'b1_0_0_1_1_0_10_00_10_00;
    localparam logic [13:0] CTL_FETCH_WT  = 14'b1_0_0_0_0_0_10_00_10_00;
    localparam logic [13:0] CTL_DECODE    = 14'b0_0_0_0_0_0_00_01_01_00;
    localparam logic [13:0] CTL_MEMADR    = 14'b0_0_0_0_0_0_00_10_01_00;
    localparam logic [13:0] CTL_MEMREAD   = 14'b1_0_1_0_0_0_00_00_00_00;
    localparam logic [13:0] CTL_MEMWB     = 14'b0_0_0_0_0_1_01_00_00_00;
    localparam logic [13:0] CTL_MEMWRITE  = 14'b1_1_1_0_0_0_00_00_00_00;
    localparam logic [13:0] CTL_EXECR     = 14'b0_0_0_0_0_0_00_10_00_10;
    localparam logic [13:0] CTL_EXECI     = 14'b0_0_0_0_0_0_00_10_01_10;
    localparam logic [13:0] CTL_ALUWB     = 14'b0_0_0_0_0_1_00_00_00_00;
    localparam logic [13:0] CTL_BEQ_T     = 14'b0_0_0_0_1_0_00_10_00_01;
    localparam logic [13:0] CTL_BEQ_NT    = 14'b0_0_0_0_0_0_00_10_00_01;
    localparam logic [13:0] CTL_JAL       = 14'b0_0_0_0_1_0_00_01_10_00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic        Zero;
    logic        mem_ready;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic        illegal, bus_err;
    logic [31:0] instret;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ret = '0;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .MemWrite  (MemWrite),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ImmSrc    (ImmSrc),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .instret   (instret)
    );

    wire logic [13:0] ctl_obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkStep(input string tag, input logic [13:0] exp_ctl, input logic [1:0] exp_imm,
                             input logic exp_ill, input logic exp_bus);
        checkOutput({tag, ".ctl"}, 32'(ctl_obs), 32'(exp_ctl));
        checkOutput({tag, ".ImmSrc"}, 32'(ImmSrc), 32'(exp_imm));
        checkOutput({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
        checkOutput({tag, ".bus_err"}, 32'(bus_err), 32'(exp_bus));
        checkOutput({tag, ".instret"}, instret, exp_ret);
    endtask

    task automatic applyStimulus(input logic [6:0] op_in, input logic ready_in, input logic zero_in);
        @(negedge clk);
        op        = op_in;
        mem_ready = ready_in;
        Zero      = zero_in;
        #1;
    endtask

    task automatic retired();
`ifdef MC_PERF_CNT_EN
        exp_ret = exp_ret + 32'd1;
`endif
    endtask

    // Assert reset asynchronously between edges, then release; the cycle after
    // release is START.
    task automatic resetPulse(input string tag);
        @(negedge clk);
        rst_n   = 1'b0;
        exp_ret = '0;
        #1;
        checkStep({tag, ".in_reset"}, CTL_IDLE, ImmSrc === 2'bxx ? 2'b00 : exp_imm_of(op), 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkStep({tag, ".start"}, CTL_IDLE, exp_imm_of(op), 1'b0, 1'b0);
    endtask

    function automatic logic [1:0] exp_imm_of(input logic [6:0] o);
        if (o == OP_SW)  return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    initial begin
        rst_n     = 1'b0;
        op        = OP_BAD;
        Zero      = 1'b0;
        mem_ready = 1'b0;
        $display("[TB] start");

        repeat (2) @(negedge clk);
        #1;
        checkStep("por.in_reset", CTL_IDLE, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkStep("por.start", CTL_IDLE, 2'b00, 1'b0, 1'b0);

        // Program SW, JAL, I-ALU for the retirement counter.
        applyStimulus(OP_SW, 1'b1, 1'b0);   checkStep("sw.fetch", CTL_FETCH_RDY, 2'b01, 1'b0, 1'b0);
        applyStimulus(OP_SW, 1'b0, 1'b0);   checkStep("sw.decode", CTL_DECODE, 2'b01, 1'b0, 1'b0);
        applyStimulus(OP_SW, 1'b0, 1'b0);   checkStep("sw.memadr", CTL_MEMADR, 2'b01, 1'b0, 1'b0);
        applyStimulus(OP_SW, 1'b1, 1'b0);   checkStep("sw.memwrite", CTL_MEMWRITE, 2'b01, 1'b0, 1'b0);
        retired();
        applyStimulus(OP_JAL, 1'b1, 1'b0);  checkStep("jal.fetch", CTL_FETCH_RDY, 2'b11, 1'b0, 1'b0);
        applyStimulus(OP_JAL, 1'b0, 1'b0);  checkStep("jal.decode", CTL_DECODE, 2'b11, 1'b0, 1'b0);
        applyStimulus(OP_JAL, 1'b0, 1'b0);  checkStep("jal.jal", CTL_JAL, 2'b11, 1'b0, 1'b0);
        applyStimulus(OP_JAL, 1'b0, 1'b0);  checkStep("jal.aluwb", CTL_ALUWB, 2'b11, 1'b0, 1'b0);
        retired();
        applyStimulus(OP_IALU, 1'b1, 1'b0); checkStep("ialu.fetch", CTL_FETCH_RDY, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_IALU, 1'b0, 1'b0); checkStep("ialu.decode", CTL_DECODE, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_IALU, 1'b0, 1'b0); checkStep("ialu.execi", CTL_EXECI, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_IALU, 1'b0, 1'b0); checkStep("ialu.aluwb", CTL_ALUWB, 2'b00, 1'b0, 1'b0);
        retired();

        // R-type with memory always ready.
        applyStimulus(OP_R, 1'b1, 1'b0);    checkStep("r.fetch", CTL_FETCH_RDY, 2'b00, 1'b0, 1'b0);
`ifdef MC_PERF_CNT_EN
        checkOutput("prog.instret", instret, 32'd3);
`else
        checkOutput("prog.instret", instret, 32'd0);
`endif
        applyStimulus(OP_R, 1'b1, 1'b0);    checkStep("r.decode", CTL_DECODE, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_R, 1'b1, 1'b0);    checkStep("r.execr", CTL_EXECR, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_R, 1'b1, 1'b0);    checkStep("r.aluwb", CTL_ALUWB, 2'b00, 1'b0, 1'b0);
        retired();

        // LW with three wait cycles in MEMREAD.
        applyStimulus(OP_LW, 1'b1, 1'b0);   checkStep("lw.fetch", CTL_FETCH_RDY, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_LW, 1'b0, 1'b0);   checkStep("lw.decode", CTL_DECODE, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_LW, 1'b0, 1'b0);   checkStep("lw.memadr", CTL_MEMADR, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OP_LW, 1'b0, 1'b0);
            checkStep($sformatf("lw.memread_wait%0d", i), CTL_MEMREAD, 2'b00, 1'b0, 1'b0);
        end
        applyStimulus(OP_LW, 1'b1, 1'b0);   checkStep("lw.memread_rdy", CTL_MEMREAD, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_LW, 1'b1, 1'b0);   checkStep("lw.memwb", CTL_MEMWB, 2'b00, 1'b0, 1'b0);
        retired();

        // BEQ taken, then not taken.
        applyStimulus(OP_BEQ, 1'b1, 1'b0);  checkStep("beqt.fetch", CTL_FETCH_RDY, 2'b10, 1'b0, 1'b0);
        applyStimulus(OP_BEQ, 1'b0, 1'b1);  checkStep("beqt.decode", CTL_DECODE, 2'b10, 1'b0, 1'b0);
        applyStimulus(OP_BEQ, 1'b0, 1'b1);  checkStep("beqt.beq", CTL_BEQ_T, 2'b10, 1'b0, 1'b0);
        retired();
        applyStimulus(OP_BEQ, 1'b1, 1'b1);  checkStep("beqn.fetch", CTL_FETCH_RDY, 2'b10, 1'b0, 1'b0);
        applyStimulus(OP_BEQ, 1'b0, 1'b0);  checkStep("beqn.decode", CTL_DECODE, 2'b10, 1'b0, 1'b0);
        applyStimulus(OP_BEQ, 1'b1, 1'b0);  checkStep("beqn.beq", CTL_BEQ_NT, 2'b10, 1'b0, 1'b0);
        retired();

        // Fetch timeout: five unanswered cycles, then TRAP with bus_err.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(OP_R, 1'b0, 1'b0);
            checkStep($sformatf("tmo.fetch_wait%0d", i), CTL_FETCH_WT, 2'b00, 1'b0, 1'b0);
        end
        applyStimulus(OP_R, 1'b0, 1'b0);    checkStep("tmo.trap", CTL_IDLE, 2'b00, 1'b0, 1'b1);
        applyStimulus(OP_R, 1'b1, 1'b0);    checkStep("tmo.trap_hold", CTL_IDLE, 2'b00, 1'b0, 1'b1);
        resetPulse("tmo.rst");

        // Ready arriving on the expiry cycle wins.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_R, 1'b0, 1'b0);
            checkStep($sformatf("late.fetch_wait%0d", i), CTL_FETCH_WT, 2'b00, 1'b0, 1'b0);
        end
        applyStimulus(OP_R, 1'b1, 1'b0);    checkStep("late.fetch_rdy", CTL_FETCH_RDY, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_R, 1'b0, 1'b0);    checkStep("late.decode", CTL_DECODE, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_R, 1'b0, 1'b0);    checkStep("late.execr", CTL_EXECR, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_R, 1'b0, 1'b0);    checkStep("late.aluwb", CTL_ALUWB, 2'b00, 1'b0, 1'b0);
        retired();

        // Unsupported opcode traps with a sticky illegal flag.
        applyStimulus(OP_BAD, 1'b1, 1'b0);  checkStep("ill.fetch", CTL_FETCH_RDY, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_BAD, 1'b0, 1'b0);  checkStep("ill.decode", CTL_DECODE, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_BAD, 1'b0, 1'b0);  checkStep("ill.trap", CTL_IDLE, 2'b00, 1'b1, 1'b0);
        applyStimulus(OP_BAD, 1'b1, 1'b1);  checkStep("ill.trap_hold", CTL_IDLE, 2'b00, 1'b1, 1'b0);
        resetPulse("ill.rst");

        // Reset landing in MEMREAD abandons the load.
        applyStimulus(OP_LW, 1'b1, 1'b0);   checkStep("abort.fetch", CTL_FETCH_RDY, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_LW, 1'b0, 1'b0);   checkStep("abort.decode", CTL_DECODE, 2'b00, 1'b0, 1'b0);
        applyStimulus(OP_LW, 1'b0, 1'b0);   checkStep("abort.memadr", CTL_MEMADR, 2'b00, 1'b0, 1'b0);
        resetPulse("abort.rst");
        applyStimulus(OP_LW, 1'b0, 1'b0);   checkStep("abort.refetch", CTL_FETCH_WT, 2'b00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
